// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  // Default number of WAIT cycles allowed before a transaction is aborted.
  localparam int unsigned DEFAULT_TIMEOUT = 32'd255;

  // Transaction FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Which requester owns (or last owned) the memory port.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  // Byte address to word address: low two bits cleared.
  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return byte_addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a single-outstanding
// memory interface. Alternating priority on ties, timeout abort in WAIT.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic        i_clk,
  input  logic        i_reset,
  // fetch port
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  // load/store port
  input  logic        i_ls_req,
  input  logic [31:0] i_ls_addr,
  input  logic        i_ls_wren,
  input  logic [31:0] i_ls_wdata,
  input  logic [3:0]  i_ls_bmask,
  output logic        o_ls_gnt,
  output logic        o_ls_rvalid,
  // shared response
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  // memory side
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_wren,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Last WAIT cycle index: the counter starts at 0, so TIMEOUT_CYCLES
  // elapsed WAIT cycles end on count TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q,     state_d;
  owner_e           owner_q,     owner_d;
  owner_e           last_q,      last_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             mem_req_q,   mem_req_d;
  logic [31:0]      mem_addr_q,  mem_addr_d;
  logic             mem_wren_q,  mem_wren_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [3:0]       mem_bmask_q, mem_bmask_d;
  logic [31:0]      rdata_q,     rdata_d;
  logic             err_q,       err_d;
  logic             if_rvalid_q, if_rvalid_d;
  logic             ls_rvalid_q, ls_rvalid_d;

  logic             pick_ls_s;
  logic             if_gnt_s;
  logic             ls_gnt_s;
  logic             timeout_s;

  // Arbitration: a lone requester wins; on a tie the port not granted last wins.
  always_comb begin
    pick_ls_s = i_ls_req & (~i_if_req | (last_q == OWN_IF));
    if_gnt_s  = (state_q == ST_IDLE) & ~i_reset & i_if_req & ~pick_ls_s;
    ls_gnt_s  = (state_q == ST_IDLE) & ~i_reset & pick_ls_s;
    timeout_s = (cnt_q == CNT_LAST);
  end

  // Next-state logic for the FSM, transaction registers and response.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    mem_req_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wren_d  = mem_wren_q;
    mem_wdata_d = mem_wdata_q;
    mem_bmask_d = mem_bmask_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (if_gnt_s) begin
          state_d     = ST_WAIT;
          owner_d     = OWN_IF;
          last_d      = OWN_IF;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_addr_d  = word_addr(i_if_addr);
          mem_wren_d  = 1'b0;
          mem_wdata_d = 32'h0000_0000;
          mem_bmask_d = 4'hF;
        end else if (ls_gnt_s) begin
          state_d     = ST_WAIT;
          owner_d     = OWN_LS;
          last_d      = OWN_LS;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_addr_d  = word_addr(i_ls_addr);
          mem_wren_d  = i_ls_wren;
          mem_wdata_d = i_ls_wdata;
          mem_bmask_d = i_ls_bmask;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (i_mem_ack) begin
          // An ack on the final cycle still counts as success.
          state_d     = ST_RESP;
          rdata_d     = mem_wren_q ? 32'h0000_0000 : i_mem_rdata;
          err_d       = 1'b0;
          if_rvalid_d = (owner_q == OWN_IF);
          ls_rvalid_d = (owner_q == OWN_LS);
        end else if (timeout_s) begin
          state_d     = ST_RESP;
          rdata_d     = 32'h0000_0000;
          err_d       = 1'b1;
          if_rvalid_d = (owner_q == OWN_IF);
          ls_rvalid_d = (owner_q == OWN_LS);
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          mem_req_d = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      last_q      <= OWN_LS;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_wren_q  <= 1'b0;
      mem_wdata_q <= 32'h0000_0000;
      mem_bmask_q <= 4'h0;
      rdata_q     <= 32'h0000_0000;
      err_q       <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wren_q  <= mem_wren_d;
      mem_wdata_q <= mem_wdata_d;
      mem_bmask_q <= mem_bmask_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
    end
  end

  // Grants are same-cycle; rvalid is masked by reset so a reset landing in
  // RESP aborts the response instead of emitting it.
  assign o_if_gnt    = if_gnt_s;
  assign o_ls_gnt    = ls_gnt_s;
  assign o_if_rvalid = if_rvalid_q & ~i_reset;
  assign o_ls_rvalid = ls_rvalid_q & ~i_reset;
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = err_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wren  = mem_wren_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_bmask = mem_bmask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter (TIMEOUT_CYCLES = 4).
module tb_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt, o_if_rvalid;
  logic        i_ls_req;
  logic [31:0] i_ls_addr;
  logic        i_ls_wren;
  logic [31:0] i_ls_wdata;
  logic [3:0]  i_ls_bmask;
  logic        o_ls_gnt, o_ls_rvalid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        o_mem_wren;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  typedef struct packed {
    logic        is_ls;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_if_req    (i_if_req),
    .i_if_addr   (i_if_addr),
    .o_if_gnt    (o_if_gnt),
    .o_if_rvalid (o_if_rvalid),
    .i_ls_req    (i_ls_req),
    .i_ls_addr   (i_ls_addr),
    .i_ls_wren   (i_ls_wren),
    .i_ls_wdata  (i_ls_wdata),
    .i_ls_bmask  (i_ls_bmask),
    .o_ls_gnt    (o_ls_gnt),
    .o_ls_rvalid (o_ls_rvalid),
    .o_rsp_rdata (o_rsp_rdata),
    .o_rsp_err   (o_rsp_err),
    .o_mem_req   (o_mem_req),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wren  (o_mem_wren),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_bmask (o_mem_bmask),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every rvalid pops one expected response and compares it.
  always @(negedge clk) begin
    if (o_if_rvalid === 1'b1 || o_ls_rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rvalid: got if=%b ls=%b expected none at %0t",
                 o_if_rvalid, o_ls_rvalid, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk1("rsp_both_rvalid", o_if_rvalid & o_ls_rvalid, 1'b0);
        chk1("rsp_port_is_ls", o_ls_rvalid, mon_e.is_ls);
        chk("rsp_rdata", o_rsp_rdata, mon_e.rdata);
        chk1("rsp_err", o_rsp_err, mon_e.err);
      end
    end
    if (o_if_gnt === 1'b1 && o_ls_gnt === 1'b1) begin
      tests++;
      fails++;
      $display("FAIL dual_gnt: got both gnt expected one at %0t", $time);
    end
  end

  // One complete transaction: grant, WAIT cycles (ack on ack_cyc or none), RESP.
  task automatic txn(input logic is_ls, input logic [31:0] addr, input logic wren,
                     input logic [31:0] wdata, input logic [3:0] bmask,
                     input int ack_cyc, input logic [31:0] mrdata,
                     input logic [31:0] e_addr, input logic e_wren,
                     input logic [31:0] e_wdata, input logic [3:0] e_bmask,
                     input logic [31:0] e_rdata, input logic e_err);
    int n;
    n = (ack_cyc > 0) ? ack_cyc : TO;
    if (is_ls) begin
      i_ls_req = 1'b1; i_ls_addr = addr; i_ls_wren = wren;
      i_ls_wdata = wdata; i_ls_bmask = bmask;
    end else begin
      i_if_req = 1'b1; i_if_addr = addr;
    end
    @(negedge clk);
    chk1("gnt_if_c0", o_if_gnt, ~is_ls);
    chk1("gnt_ls_c0", o_ls_gnt, is_ls);
    chk1("mem_req_c0", o_mem_req, 1'b0);
    exp_q.push_back('{is_ls, e_rdata, e_err});
    step();
    i_if_req = 1'b0;
    i_ls_req = 1'b0;
    for (int c = 1; c <= n; c++) begin
      if (c == ack_cyc) begin
        i_mem_ack = 1'b1;
        i_mem_rdata = mrdata;
      end
      @(negedge clk);
      chk1("mem_req_wait", o_mem_req, 1'b1);
      chk("mem_addr", o_mem_addr, e_addr);
      chk1("mem_wren", o_mem_wren, e_wren);
      chk("mem_wdata", o_mem_wdata, e_wdata);
      chk("mem_bmask", {28'd0, o_mem_bmask}, {28'd0, e_bmask});
      step();
      i_mem_ack = 1'b0;
      i_mem_rdata = 32'h0;
    end
    @(negedge clk);
    chk1("rvalid_resp", is_ls ? o_ls_rvalid : o_if_rvalid, 1'b1);
    chk1("mem_req_resp", o_mem_req, 1'b0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1; i_if_req = 1'b0; i_if_addr = 32'h0;
    i_ls_req = 1'b0; i_ls_addr = 32'h0; i_ls_wren = 1'b0;
    i_ls_wdata = 32'h0; i_ls_bmask = 4'h0;
    i_mem_ack = 1'b0; i_mem_rdata = 32'h0;
    step();
    step();
    // Reset state, including a request held during reset.
    i_if_req = 1'b1;
    @(negedge clk);
    chk1("rst_if_gnt", o_if_gnt, 1'b0);
    chk1("rst_mem_req", o_mem_req, 1'b0);
    chk("rst_mem_addr", o_mem_addr, 32'h0);
    chk("rst_mem_bmask", {28'd0, o_mem_bmask}, 32'h0);
    chk("rst_rdata", o_rsp_rdata, 32'h0);
    chk1("rst_if_rvalid", o_if_rvalid, 1'b0);
    step();
    i_if_req = 1'b0;
    i_reset = 1'b0;

    // Fetch 0x10, ack on 3rd WAIT cycle.
    txn(1'b0, 32'h10, 1'b0, 32'h0, 4'h0, 3, 32'h13,
        32'h10, 1'b0, 32'h0, 4'hF, 32'h13, 1'b0);
    // Unaligned store: write data never returned.
    txn(1'b1, 32'h7003, 1'b1, 32'hDEADBEEF, 4'b1000, 1, 32'h55,
        32'h7000, 1'b1, 32'hDEADBEEF, 4'b1000, 32'h0, 1'b0);
    // Load, ack on 2nd cycle.
    txn(1'b1, 32'h24, 1'b0, 32'h11112222, 4'hF, 2, 32'hCAFEF00D,
        32'h24, 1'b0, 32'h11112222, 4'hF, 32'hCAFEF00D, 1'b0);
    // Fetch timeout: 4 WAIT cycles, no ack.
    txn(1'b0, 32'h42, 1'b0, 32'h0, 4'h0, 0, 32'h0,
        32'h40, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1);
    // Ack coincident with the last allowed WAIT cycle wins over timeout.
    txn(1'b1, 32'h88, 1'b0, 32'h0, 4'h3, 4, 32'hA5A5A5A5,
        32'h88, 1'b0, 32'h0, 4'h3, 32'hA5A5A5A5, 1'b0);

    // Fresh reset, then both ports held: fetch, LSU, fetch.
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    i_if_req = 1'b1; i_if_addr = 32'h100;
    i_ls_req = 1'b1; i_ls_addr = 32'h203; i_ls_wren = 1'b0;
    i_ls_wdata = 32'h0; i_ls_bmask = 4'h3;
    for (int g = 0; g < 3; g++) begin
      logic exp_ls;
      exp_ls = (g == 1);
      @(negedge clk);
      chk1("alt_gnt_if", o_if_gnt, ~exp_ls);
      chk1("alt_gnt_ls", o_ls_gnt, exp_ls);
      exp_q.push_back('{exp_ls, 32'h1000 + 32'(g), 1'b0});
      step();
      i_mem_ack = 1'b1;
      i_mem_rdata = 32'h1000 + 32'(g);
      @(negedge clk);
      chk("alt_mem_addr", o_mem_addr, exp_ls ? 32'h200 : 32'h100);
      chk1("alt_no_gnt_wait", o_if_gnt | o_ls_gnt, 1'b0);
      step();
      i_mem_ack = 1'b0;
      i_mem_rdata = 32'h0;
      @(negedge clk);
      chk1("alt_no_gnt_resp", o_if_gnt | o_ls_gnt, 1'b0);
      step();
    end
    i_if_req = 1'b0;
    i_ls_req = 1'b0;

    // Reset in WAIT, then a stray ack while idle.
    i_if_req = 1'b1; i_if_addr = 32'h300;
    @(negedge clk);
    chk1("rw_gnt", o_if_gnt, 1'b1);
    step();
    i_if_req = 1'b0;
    @(negedge clk);
    chk1("rw_mem_req_wait", o_mem_req, 1'b1);
    step();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    i_mem_ack = 1'b1;
    i_mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk1("rw_mem_req_after", o_mem_req, 1'b0);
    chk1("rw_no_gnt", o_if_gnt | o_ls_gnt, 1'b0);
    step();
    i_mem_ack = 1'b0;
    i_mem_rdata = 32'h0;
    @(negedge clk);
    chk1("rw_no_rvalid", o_if_rvalid | o_ls_rvalid, 1'b0);
    chk1("rw_mem_req_idle", o_mem_req, 1'b0);
    step();
    // After reset, fetch wins the first tie again.
    i_if_req = 1'b1; i_ls_req = 1'b1;
    @(negedge clk);
    chk1("rw_tie_if", o_if_gnt, 1'b1);
    chk1("rw_tie_ls", o_ls_gnt, 1'b0);
    exp_q.push_back('{1'b0, 32'h77, 1'b0});
    step();
    i_if_req = 1'b0; i_ls_req = 1'b0;
    i_mem_ack = 1'b1; i_mem_rdata = 32'h77;
    step();
    i_mem_ack = 1'b0; i_mem_rdata = 32'h0;
    @(negedge clk);
    chk1("rw_tie_rvalid", o_if_rvalid, 1'b1);
    step();
    step();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
